// File: rtl/riscv_fetch_unit.sv
// rtl/riscv_fetch_unit.sv - RISC-V instruction fetch front end with prefetch queue and redirect flush
module riscv_fetch_unit #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 10,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [XLEN-1:0]   imem_rsp_data,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [XLEN-1:0]   if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_npc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] ent_pc    [DEPTH];
    logic [XLEN-1:0]   ent_instr [DEPTH];
    logic [DEPTH-1:0]  ent_filled;
    logic [PW-1:0]     head, tail, fill_ptr;
    logic [CW-1:0]     alloc, unfilled, discard_cnt;

    logic          credit_ok, req_fire, rsp_drop, rsp_fill, pop;
    logic [CW-1:0] disc_sum, disc_redirect;

    // Credits cover queued entries plus responses still owed to a flushed stream.
    assign credit_ok      = ({1'b0, alloc} + {1'b0, discard_cnt}) < (CW+1)'(DEPTH);
    assign imem_req_valid = rst_n && !halt && !redirect_valid && credit_ok;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop = imem_rsp_valid && (discard_cnt != '0);
    assign rsp_fill = imem_rsp_valid && !redirect_valid && (discard_cnt == '0) && (unfilled != '0);

    assign if_valid = ent_filled[head] && !redirect_valid;
    assign if_instr = ent_instr[head];
    assign if_pc    = ent_pc[head];
    assign if_npc   = ent_filled[head] ? ent_pc[head] + 1'b1 : '0;
    assign pop      = if_valid && if_ready;

    // A response arriving in the redirect cycle is one of the owed ones, so it is already consumed.
    assign disc_sum      = discard_cnt + unfilled;
    assign disc_redirect = (imem_rsp_valid && disc_sum != '0) ? disc_sum - 1'b1 : disc_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= ADDR_W'(RESET_PC);
            head        <= '0;
            tail        <= '0;
            fill_ptr    <= '0;
            alloc       <= '0;
            unfilled    <= '0;
            discard_cnt <= '0;
            ent_filled  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_pc[i]    <= '0;
                ent_instr[i] <= '0;
            end
        end else if (redirect_valid) begin
            pc          <= redirect_pc;
            head        <= '0;
            tail        <= '0;
            fill_ptr    <= '0;
            alloc       <= '0;
            unfilled    <= '0;
            discard_cnt <= disc_redirect;
            ent_filled  <= '0;
        end else begin
            if (rsp_drop) begin
                discard_cnt <= discard_cnt - 1'b1;
            end
            if (req_fire) begin
                ent_pc[tail]     <= pc;
                ent_filled[tail] <= 1'b0;
                tail             <= tail + 1'b1;
                pc               <= pc + 1'b1;
            end
            if (rsp_fill) begin
                ent_instr[fill_ptr]  <= imem_rsp_data;
                ent_filled[fill_ptr] <= 1'b1;
                fill_ptr             <= fill_ptr + 1'b1;
            end
            if (pop) begin
                ent_filled[head] <= 1'b0;
                head             <= head + 1'b1;
            end
            alloc    <= alloc + CW'(req_fire) - CW'(pop);
            unfilled <= unfilled + CW'(req_fire) - CW'(rsp_fill);
        end
    end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb/tb_riscv_fetch_unit.sv - randomized bench for riscv_fetch_unit against a queue-based fetch model
module tb_riscv_fetch_unit;

    localparam int XLEN  = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          halt = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          imem_req_valid;
    logic          imem_req_ready = 1'b0;
    logic [AW-1:0] imem_req_addr;
    logic          imem_rsp_valid = 1'b0;
    logic [XLEN-1:0] imem_rsp_data = '0;
    logic          if_valid;
    logic          if_ready = 1'b0;
    logic [XLEN-1:0] if_instr;
    logic [AW-1:0] if_pc;
    logic [AW-1:0] if_npc;

    always #5 clk = ~clk;

    riscv_fetch_unit #(.XLEN(XLEN), .ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC(0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_npc         (if_npc)
    );

    typedef struct {
        logic [AW-1:0] pc;
        bit            filled;
    } ent_t;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
        bit            stale;
    } mreq_t;

    ent_t          q[$];
    mreq_t         pend[$];
    logic [AW-1:0] exp_pc;
    int            cyc, last_due, lat_min, lat_max;
    int            n_cmp, n_bad;
    int            pops, fires;
    logic [AW-1:0] pop_pc;
    logic [XLEN-1:0] pop_instr;

    function automatic logic [XLEN-1:0] mem_word(input logic [AW-1:0] a);
        return 32'h100 + XLEN'(a);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int stale_cnt();
        int n = 0;
        foreach (pend[i]) if (pend[i].stale) n++;
        return n;
    endfunction

    function automatic int unfilled_cnt();
        int n = 0;
        foreach (q[i]) if (!q[i].filled) n++;
        return n;
    endfunction

    function automatic bit rsp_due();
        return pend.size() > 0 && pend[0].due <= cyc;
    endfunction

    task automatic step(input bit h, input bit rdy, input bit rv, input logic [AW-1:0] rpc, input bit qrdy);
        bit            rsp, exp_rv, exp_iv, placed;
        mreq_t         r;
        ent_t          e;
        mreq_t         m;
        int            d;
        logic [AW-1:0] nx;
        @(negedge clk);
        halt           = h;
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_req_ready = qrdy;
        rsp = rsp_due();
        if (rsp) begin
            r = pend.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(r.addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        exp_rv = !h && !rv && (q.size() + stale_cnt() < DEPTH);
        check("req_valid", imem_req_valid, exp_rv);
        if (exp_rv) check("req_addr", imem_req_addr, exp_pc);
        exp_iv = q.size() > 0 && q[0].filled && !rv;
        check("if_valid", if_valid, exp_iv);
        if (exp_iv) begin
            nx = q[0].pc + 1'b1;
            check("if_pc", if_pc, q[0].pc);
            check("if_instr", if_instr, mem_word(q[0].pc));
            check("if_npc", if_npc, nx);
        end
        if (rv) begin
            q.delete();
            exp_pc = rpc;
            foreach (pend[i]) pend[i].stale = 1'b1;
        end else begin
            if (rsp && !r.stale) begin
                placed = 1'b0;
                foreach (q[i]) begin
                    if (!placed && !q[i].filled) begin
                        q[i].filled = 1'b1;
                        placed = 1'b1;
                    end
                end
                if (!placed) check("rsp_orphan", 1, 0);
            end
            if (exp_iv && rdy) begin
                pop_pc    = if_pc;
                pop_instr = if_instr;
                void'(q.pop_front());
                pops++;
            end
            if (exp_rv && qrdy) begin
                e.pc = exp_pc;
                e.filled = 1'b0;
                q.push_back(e);
                d = cyc + $urandom_range(lat_max, lat_min);
                if (pend.size() > 0 && d <= last_due) d = last_due + 1;
                last_due = d;
                m.addr = exp_pc;
                m.due = d;
                m.stale = 1'b0;
                pend.push_back(m);
                exp_pc = exp_pc + 1'b1;
                fires++;
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        #1;
        check("rst_if_valid", if_valid, 0);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_req_addr", imem_req_addr, 0);
        check("rst_if_instr", if_instr, 0);
        check("rst_if_pc", if_pc, 0);
        check("rst_if_npc", if_npc, 0);
        q.delete();
        pend.delete();
        exp_pc   = '0;
        last_due = 0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        cyc++;
    endtask

    // Step until the first decode pop, bounded, and return whether one happened.
    task automatic run_to_pop(input int budget, output bit got);
        int p0;
        p0  = pops;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            step(0, 1, 0, '0, 1);
            if (pops != p0) got = 1'b1;
        end
    endtask

    initial begin
        bit got, found;
        n_cmp = 0; n_bad = 0; cyc = 0; last_due = 0;
        lat_min = 1; lat_max = 1;
        exp_pc = '0;

        // Streaming at latency 1: two startup cycles, then one instruction per cycle.
        do_reset();
        pops = 0;
        for (int i = 0; i < 20; i++) step(0, 1, 0, '0, 1);
        check("stream_rate", pops, 18);

        // Backpressure: only DEPTH requests accepted while decode stalls.
        do_reset();
        fires = 0;
        for (int i = 0; i < 10; i++) step(0, 0, 0, '0, 1);
        check("bp_fires", fires, DEPTH);
        for (int i = 0; i < 10; i++) step(0, 1, 0, '0, 1);

        // Redirect with two unfilled entries at latency 3.
        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (unfilled_cnt() == 2) found = 1'b1;
            else step(0, 1, 0, '0, 1);
        end
        check("p3_setup", found, 1);
        step(0, 1, 1, 10'h020, 1);
        run_to_pop(20, got);
        check("p3_pop_seen", got, 1);
        check("p3_pop_pc", pop_pc, 10'h020);
        check("p3_pop_instr", pop_instr, mem_word(10'h020));
        for (int i = 0; i < 8; i++) step(0, 1, 0, '0, 1);
        check("p3_discards_done", stale_cnt(), 0);

        // Redirect in the same cycle as a response and a ready, filled head.
        lat_min = 1; lat_max = 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (rsp_due() && q.size() > 0 && q[0].filled) found = 1'b1;
            else step(0, 1, 0, '0, 1);
        end
        check("p4_setup", found, 1);
        step(0, 1, 1, 10'h040, 1);
        run_to_pop(20, got);
        check("p4_pop_pc", pop_pc, 10'h040);

        // PC wrap at the top of the address space.
        step(0, 1, 1, 10'h3FE, 1);
        for (int i = 0; i < 8; i++) step(0, 1, 0, '0, 1);

        // Halt with three entries queued: they drain, no new requests.
        step(0, 0, 1, 10'h080, 1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (q.size() == 3) found = 1'b1;
            else step(0, 0, 0, '0, 1);
        end
        check("p6_setup", found, 1);
        fires = 0; pops = 0;
        for (int i = 0; i < 8; i++) step(1, 1, 0, '0, 1);
        check("halt_fires", fires, 0);
        check("halt_drained", pops, 3);
        for (int i = 0; i < 6; i++) step(0, 1, 0, '0, 1);

        // Asynchronous reset in the middle of a stream.
        do_reset();
        for (int i = 0; i < 10; i++) step(0, 1, 0, '0, 1);

        // Random traffic.
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(9, 0) == 0, $urandom_range(9, 0) < 7,
                 $urandom_range(19, 0) == 0, AW'($urandom), $urandom_range(9, 0) < 8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_fetch_unit.md
Name: riscv_fetch_unit

Overview:
- Instruction-fetch front end that drives the IF/ID boundary of the 32-bit pipelined RISC-V core.
- Generates word addresses into instruction memory and tracks in-order responses in a small prefetch queue.
- Presents {instruction, PC, NPC} to the decode stage through a valid/ready handshake.
- Absorbs taken-branch redirects from EX by flushing the queue and discarding in-flight responses.

Parameters:
XLEN, 32, instruction and data width
ADDR_W, 10, word-address width; PC wraps modulo 2^ADDR_W
DEPTH, 4, prefetch queue entries; power of two, at least 2
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  single core clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
halt  in  1  level; blocks new fetch requests while 1
redirect_valid  in  1  taken branch from EX, single-cycle pulse
redirect_pc  in  ADDR_W  branch target word address
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  word address of request
imem_rsp_valid  in  1  response valid; in order, no backpressure, at most 1 per cycle, latency at least 1 cycle
imem_rsp_data  in  XLEN  instruction word
if_valid  out  1  instruction available to decode
if_ready  in  1  decode accepts
if_instr  out  XLEN  instruction
if_pc  out  ADDR_W  address of if_instr
if_npc  out  ADDR_W  if_pc+1, wrapped

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert):
  - pc=RESET_PC; queue empty (alloc=0); discard_cnt=0.
  - imem_req_valid=0, if_valid=0, if_instr=0, if_pc=0, if_npc=0.
- Queue entry fields: {pc, instr, filled}.
  - Allocated at request handshake, with pc recorded.
  - filled set when its response arrives.
  - Freed at decode pop.
- Request issue:
  - imem_req_valid = !halt && !redirect_valid && (alloc + discard_cnt < DEPTH). Combinational; imem_req_addr = pc.
  - On handshake: allocate a tail entry, pc <= pc+1 (wrapping from 2^ADDR_W-1 to 0). 1 request per cycle max.
  - The credit rule guarantees total outstanding + queued ≤ DEPTH; the queue never overflows.
- Response handling:
  - discard_cnt>0: response dropped, discard_cnt decrements.
  - Otherwise: fills the oldest unfilled entry.
  - Response with nothing outstanding is ignored; this is a protocol violation and is asserted in the bench.
- Decode output:
  - if_valid = head.filled && !redirect_valid. if_instr/if_pc/if_npc come from the head entry (combinational from queue state).
  - Pop on if_valid && if_ready.
  - Head payload must stay stable while if_valid && !if_ready.
- Redirect (highest priority, same cycle):
  - No request issued, no pop, no response fill.
  - pc <= redirect_pc.
  - All entries freed (alloc=0).
  - discard_cnt <= discard_cnt + unfilled_entries − (imem_rsp_valid ? 1 : 0). The same-cycle response counts as already discarded.
- Simultaneous events without redirect: request, response fill and pop may all occur in one cycle. Occupancy update = +req − pop.
- halt:
  - Stops requests only; already-allocated entries still fill and drain to decode.
  - Deassert resumes fetch at the current pc with no lost or duplicated address.
- Back-to-back throughput: with 1-cycle memory latency and if_ready=1, one instruction per cycle sustained after a 2-cycle startup.
- Reset mid-operation: all state returns to reset values immediately; late responses after reset are not guaranteed meaningful (memory is reset with the core).

Test Plan:
1. Streaming:
   - Stimulus: reset, mem latency 1, Mem[k]=0x100+k, if_ready=1.
   - Required: if_pc sequence 0,1,2,3…; if_instr 0x100,0x101…; if_npc=if_pc+1; one per cycle after startup.
2. Backpressure:
   - Stimulus: hold if_ready=0 for 10 cycles.
   - Required: imem_req_valid drops after exactly DEPTH=4 handshakes; if_pc=0 held stable; release yields 0,1,2,3,4 with no gaps or duplicates.
3. Redirect with in-flight responses:
   - Stimulus: mem latency 3, redirect_pc=0x20 while 2 requests are unfilled.
   - Required: those 2 responses dropped; next if_pc=0x20, if_instr=Mem[0x20]; discard_cnt returns to 0.
4. Redirect coincident with a response and a ready pop:
   - Required: no pop that cycle (if_valid=0); the coinciding response is dropped; subsequent stream starts at the target.
5. PC wrap:
   - Stimulus: redirect_pc=0x3FE.
   - Required: if_pc 0x3FE, 0x3FF, 0x000; if_npc for 0x3FF equals 0x000.
6. Halt, then async reset:
   - Stimulus: assert halt with 3 entries queued.
   - Required: those 3 still drain, no new imem_req_valid; deassert resumes at next pc. Then pulse rst_n low mid-stream: if_valid=0 and imem_req_addr=RESET_PC within the reset cycle.
